// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the multi-wide fetch stage.
//   XLEN          data/address width
//   INSTR_BYTES   bytes per instruction (PC step per lane)
//   MAX_FW        widest supported fetch width
//   fetch_entry_t queue payload {pc_p4, instr}
//   lead_ones     number of contiguous 1s starting at bit 0 of a lane mask
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned MAX_FW      = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc_p4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Counts leading 1s from lane 0; lanes at or above width are ignored.
  function automatic logic [3:0] lead_ones(input logic [MAX_FW-1:0] mask,
                                           input int unsigned width);
    logic [3:0] cnt;
    logic       run;
    cnt = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < MAX_FW; i++) begin
      if (run && (i < width) && mask[i]) cnt = cnt + 4'd1;
      else                               run = 1'b0;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mp_instr_queue.sv
// mp_instr_queue: circular queue with W write ports and W read ports.
//   CLK, Reset   clock, async active-high reset (pointers/count only)
//   Flush        synchronous clear of head/tail/Count; wins over push/pop
//   PushCount    entries written this edge at tail..tail+PushCount-1
//   PushData     write-port payloads, lane 0 first
//   PopCount     entries requested for removal (clamped to Count)
//   HeadData     combinational read of entries head..head+W-1
//   Count        occupied entries
module mp_instr_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned W     = 4,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned PW    = $clog2(W + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic [PW-1:0]        PushCount,
  input  fetch_entry_t [W-1:0] PushData,
  input  logic [PW-1:0]        PopCount,
  output fetch_entry_t [W-1:0] HeadData,
  output logic [CNT_W-1:0]     Count
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] popN;
  fetch_entry_t     mem [DEPTH];

  // Pop never exceeds what is stored.
  always_comb begin
    popN = CNT_W'(PopCount);
    if (popN > Count) popN = Count;
  end

  // Pointer and occupancy update; pointers wrap naturally at PTR_W bits.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
    end else if (Flush) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
    end else begin
      head  <= head + PTR_W'(popN);
      tail  <= tail + PTR_W'(PushCount);
      Count <= Count + CNT_W'(PushCount) - popN;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (!Flush) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (PW'(i) < PushCount) mem[tail + PTR_W'(i)] <= PushData[i];
      end
    end
  end

  // Head lanes read registered storage combinationally.
  always_comb begin
    for (int unsigned i = 0; i < W; i++) begin
      HeadData[i] = mem[head + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/fetch_stage_mw.sv
// fetch_stage_mw: multi-wide fetch stage feeding a multi-port instruction queue.
//   CLK, Reset   clock, async active-high reset
//   ImemAddr     fetch address (PC); lane i reads ImemAddr+4*i
//   ImemRdata    per-lane instruction words, lane 0 in the low 32 bits
//   ImemValid    per-lane valid; only the leading run of 1s is used
//   Branch/Jump  redirect requests with targets; Branch has priority
//   DeqCount     entries decode consumes this cycle
//   OutInstr     head-lane instructions; OutPCp4 head-lane PC+4
//   OutValid     lane i valid iff i < Count
//   Count/Full/Empty queue occupancy status
module fetch_stage_mw
  import fetch_pkg::*;
#(
  parameter  int unsigned FETCH_WIDTH = 4,
  parameter  int unsigned DEPTH       = 32,
  parameter  logic [31:0] RESET_PC    = 32'h0,
  localparam int unsigned DEQ_W       = $clog2(FETCH_WIDTH + 1),
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        Reset,
  output logic [XLEN-1:0]             ImemAddr,
  input  logic [XLEN*FETCH_WIDTH-1:0] ImemRdata,
  input  logic [FETCH_WIDTH-1:0]      ImemValid,
  input  logic                        Branch,
  input  logic [XLEN-1:0]             BranchDest,
  input  logic                        Jump,
  input  logic [XLEN-1:0]             JumpDest,
  input  logic [DEQ_W-1:0]            DeqCount,
  output logic [XLEN*FETCH_WIDTH-1:0] OutInstr,
  output logic [XLEN*FETCH_WIDTH-1:0] OutPCp4,
  output logic [FETCH_WIDTH-1:0]      OutValid,
  output logic [CNT_W-1:0]            Count,
  output logic                        Full,
  output logic                        Empty
);

  logic [XLEN-1:0]                pcReg;
  logic                           isRedirect;
  logic [XLEN-1:0]                redirectPc;
  logic [DEQ_W-1:0]               leadCount;
  logic [DEQ_W-1:0]               pushCount;
  fetch_entry_t [FETCH_WIDTH-1:0] pushData;
  fetch_entry_t [FETCH_WIDTH-1:0] headData;

  assign ImemAddr = pcReg;

  // Full uses the pre-pop count: a slot freed this cycle is not reused until next cycle.
  assign Full  = Count > CNT_W'(DEPTH - FETCH_WIDTH);
  assign Empty = (Count == '0);

  // Push-count and redirect selection.
  always_comb begin
    isRedirect = Branch | Jump;
    redirectPc = Branch ? BranchDest : JumpDest;
    leadCount  = DEQ_W'(lead_ones(MAX_FW'(ImemValid), FETCH_WIDTH));
    pushCount  = (isRedirect || Full) ? '0 : leadCount;
  end

  // Lane i carries the address of the instruction after it.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      pushData[i].pc_p4 = pcReg + XLEN'((i + 1) * INSTR_BYTES);
      pushData[i].instr = ImemRdata[i*XLEN +: XLEN];
    end
  end

  // PC register: redirect target (word aligned) or advance by pushed lanes.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pcReg <= RESET_PC;
    end else if (isRedirect) begin
      pcReg <= {redirectPc[XLEN-1:2], 2'b00};
    end else begin
      pcReg <= pcReg + (XLEN'(pushCount) * XLEN'(INSTR_BYTES));
    end
  end

  mp_instr_queue #(
    .W     (FETCH_WIDTH),
    .DEPTH (DEPTH)
  ) uQueue (
    .CLK       (CLK),
    .Reset     (Reset),
    .Flush     (isRedirect),
    .PushCount (pushCount),
    .PushData  (pushData),
    .PopCount  (DeqCount),
    .HeadData  (headData),
    .Count     (Count)
  );

  // Flatten head lanes for decode.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      OutInstr[i*XLEN +: XLEN] = headData[i].instr;
      OutPCp4[i*XLEN +: XLEN]  = headData[i].pc_p4;
      OutValid[i]              = CNT_W'(i) < Count;
    end
  end

endmodule

// File: tb/tb_fetch_stage_mw.sv
// tb_fetch_stage_mw: directed scenarios plus randomized traffic for fetch_stage_mw,
// checked against a queue-based behavioural model of the fetch stage.
module tb_fetch_stage_mw;

  localparam int FW    = 4;
  localparam int DEPTH = 32;

  logic          CLK = 1'b0;
  logic          Reset;
  logic [31:0]   ImemAddr;
  logic [127:0]  ImemRdata;
  logic [3:0]    ImemValid;
  logic          Branch;
  logic [31:0]   BranchDest;
  logic          Jump;
  logic [31:0]   JumpDest;
  logic [2:0]    DeqCount;
  logic [127:0]  OutInstr;
  logic [127:0]  OutPCp4;
  logic [3:0]    OutValid;
  logic [5:0]    Count;
  logic          Full;
  logic          Empty;

  typedef struct {
    logic [31:0] pcp4;
    logic [31:0] instr;
  } ent_t;

  ent_t        mQ[$];
  logic [31:0] mPc;
  int          passCount = 0;
  int          checkCount = 0;

  always #5 CLK = ~CLK;

  fetch_stage_mw #(
    .FETCH_WIDTH (FW),
    .DEPTH       (DEPTH),
    .RESET_PC    (32'h0)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .ImemAddr   (ImemAddr),
    .ImemRdata  (ImemRdata),
    .ImemValid  (ImemValid),
    .Branch     (Branch),
    .BranchDest (BranchDest),
    .Jump       (Jump),
    .JumpDest   (JumpDest),
    .DeqCount   (DeqCount),
    .OutInstr   (OutInstr),
    .OutPCp4    (OutPCp4),
    .OutValid   (OutValid),
    .Count      (Count),
    .Full       (Full),
    .Empty      (Empty)
  );

  function automatic logic [31:0] instrAt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Instruction memory: every lane answers combinationally.
  always_comb begin
    for (int i = 0; i < FW; i++) ImemRdata[i*32 +: 32] = instrAt(ImemAddr + 32'(4 * i));
  end

  // One clock edge, with the model advanced from the inputs seen at that edge.
  task automatic tick();
    int sz;
    int d;
    int n;
    sz = mQ.size();
    @(posedge CLK);
    if (Branch) begin
      mQ.delete();
      mPc = BranchDest & ~32'h3;
    end else if (Jump) begin
      mQ.delete();
      mPc = JumpDest & ~32'h3;
    end else begin
      d = (int'(DeqCount) > sz) ? sz : int'(DeqCount);
      repeat (d) void'(mQ.pop_front());
      if ((DEPTH - sz) >= FW) begin
        n = 0;
        while (n < FW && ImemValid[n]) n++;
        for (int i = 0; i < n; i++) begin
          ent_t e;
          e.pcp4  = mPc + 32'(4 * (i + 1));
          e.instr = instrAt(mPc + 32'(4 * i));
          mQ.push_back(e);
        end
        mPc = mPc + 32'(4 * n);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ImemValid = '0; Branch = 0; Jump = 0;
    BranchDest = '0; JumpDest = '0; DeqCount = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkCount++; if (Count !== 6'd0) $display("FAIL reset_count: got %0d expected 0", Count); else passCount++;
    checkCount++; if (Empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", Empty); else passCount++;
    checkCount++; if (Full !== 1'b0) $display("FAIL reset_full: got %b expected 0", Full); else passCount++;
    checkCount++; if (OutValid !== 4'b0) $display("FAIL reset_outvalid: got %b expected 0000", OutValid); else passCount++;
    checkCount++; if (ImemAddr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", ImemAddr); else passCount++;
    Reset = 1'b0;
    mQ.delete();
    mPc = 32'h0;
    ImemValid = 4'b1111;
    tick();
    checkCount++; if (Count !== 6'd4) $display("FAIL first_fill_count: got %0d expected 4", Count); else passCount++;
    checkCount++; if (OutPCp4 !== {32'd16, 32'd12, 32'd8, 32'd4})
      $display("FAIL first_fill_pcp4: got %h expected 00000010_0000000c_00000008_00000004", OutPCp4); else passCount++;
    checkCount++; if (ImemAddr !== 32'd16) $display("FAIL first_fill_addr: got %h expected 10", ImemAddr); else passCount++;
  endtask

  task automatic test_partial_mask();
    ImemValid = 4'b1011;
    tick();
    checkCount++; if (Count !== 6'd6) $display("FAIL partial_count: got %0d expected 6", Count); else passCount++;
    checkCount++; if (ImemAddr !== 32'd24) $display("FAIL partial_addr: got %h expected 18", ImemAddr); else passCount++;
    ImemValid = 4'b0000;
    DeqCount = 3'd4;
    tick();
    DeqCount = 3'd0;
    checkCount++; if (Count !== 6'd2) $display("FAIL partial_pop_count: got %0d expected 2", Count); else passCount++;
    checkCount++; if (OutPCp4[63:0] !== {32'd24, 32'd20})
      $display("FAIL partial_lanes_pcp4: got %h expected 00000018_00000014", OutPCp4[63:0]); else passCount++;
    checkCount++; if (OutValid !== 4'b0011) $display("FAIL partial_outvalid: got %b expected 0011", OutValid); else passCount++;
    checkCount++; if (OutInstr[31:0] !== instrAt(32'd16))
      $display("FAIL partial_instr: got %h expected %h", OutInstr[31:0], instrAt(32'd16)); else passCount++;
  endtask

  task automatic test_full_stall();
    logic [31:0] savedPc;
    int n;
    DeqCount = 3'd0;
    while (mQ.size() < 29) begin
      n = (29 - mQ.size() > 4) ? 4 : 29 - mQ.size();
      ImemValid = 4'((1 << n) - 1);
      tick();
    end
    checkCount++; if (Count !== 6'd29) $display("FAIL fill_count: got %0d expected 29", Count); else passCount++;
    checkCount++; if (Full !== 1'b1) $display("FAIL fill_full: got %b expected 1", Full); else passCount++;
    savedPc = mPc;
    ImemValid = 4'b1111;
    tick();
    checkCount++; if (Count !== 6'd29) $display("FAIL stall_count: got %0d expected 29", Count); else passCount++;
    checkCount++; if (ImemAddr !== savedPc) $display("FAIL stall_addr: got %h expected %h", ImemAddr, savedPc); else passCount++;
    DeqCount = 3'd4;
    tick();
    checkCount++; if (Count !== 6'd25) $display("FAIL stall_pop_count: got %0d expected 25", Count); else passCount++;
    checkCount++; if (Full !== 1'b0) $display("FAIL stall_pop_full: got %b expected 0", Full); else passCount++;
    checkCount++; if (ImemAddr !== savedPc) $display("FAIL stall_pop_addr: got %h expected %h", ImemAddr, savedPc); else passCount++;
    DeqCount = 3'd0;
    tick();
    checkCount++; if (Count !== 6'd29) $display("FAIL resume_count: got %0d expected 29", Count); else passCount++;
    checkCount++; if (ImemAddr !== savedPc + 32'd16)
      $display("FAIL resume_addr: got %h expected %h", ImemAddr, savedPc + 32'd16); else passCount++;
  endtask

  task automatic test_push_pop();
    logic [31:0] expHead;
    ImemValid = 4'b0000;
    while (mQ.size() > 10) begin
      DeqCount = 3'((mQ.size() - 10 > 4) ? 4 : mQ.size() - 10);
      tick();
    end
    checkCount++; if (Count !== 6'd10) $display("FAIL drain_count: got %0d expected 10", Count); else passCount++;
    expHead = mQ[3].pcp4;
    ImemValid = 4'b1111;
    DeqCount = 3'd3;
    tick();
    DeqCount = 3'd0;
    checkCount++; if (Count !== 6'd11) $display("FAIL pushpop_count: got %0d expected 11", Count); else passCount++;
    checkCount++; if (OutPCp4[31:0] !== expHead)
      $display("FAIL pushpop_head: got %h expected %h", OutPCp4[31:0], expHead); else passCount++;
  endtask

  task automatic test_redirect();
    ImemValid = 4'b0001;
    DeqCount = 3'd0;
    tick();
    checkCount++; if (Count !== 6'd12) $display("FAIL pre_redirect_count: got %0d expected 12", Count); else passCount++;
    Branch = 1'b1; BranchDest = 32'h104;
    Jump = 1'b1;   JumpDest = 32'h200;
    ImemValid = 4'b1111;
    DeqCount = 3'd2;
    tick();
    Branch = 1'b0; Jump = 1'b0;
    checkCount++; if (Count !== 6'd0) $display("FAIL redirect_count: got %0d expected 0", Count); else passCount++;
    checkCount++; if (Empty !== 1'b1) $display("FAIL redirect_empty: got %b expected 1", Empty); else passCount++;
    checkCount++; if (ImemAddr !== 32'h104) $display("FAIL redirect_addr: got %h expected 104", ImemAddr); else passCount++;
    checkCount++; if (OutValid !== 4'b0) $display("FAIL redirect_outvalid: got %b expected 0000", OutValid); else passCount++;
    tick();
    DeqCount = 3'd0;
    checkCount++; if (Count !== 6'd4) $display("FAIL target_count: got %0d expected 4", Count); else passCount++;
    checkCount++; if (OutPCp4[31:0] !== 32'h108) $display("FAIL target_pcp4: got %h expected 108", OutPCp4[31:0]); else passCount++;
    Jump = 1'b1; JumpDest = 32'h203;
    tick();
    Jump = 1'b0;
    checkCount++; if (ImemAddr !== 32'h200) $display("FAIL jump_align_addr: got %h expected 200", ImemAddr); else passCount++;
    checkCount++; if (Count !== 6'd0) $display("FAIL jump_count: got %0d expected 0", Count); else passCount++;
  endtask

  task automatic test_async_reset();
    ImemValid = 4'b1111;
    DeqCount = 3'd0;
    tick();
    ImemValid = 4'b0111;
    tick();
    checkCount++; if (Count !== 6'd7) $display("FAIL prereset_count: got %0d expected 7", Count); else passCount++;
    #3;
    Reset = 1'b1;
    #1;
    checkCount++; if (Count !== 6'd0) $display("FAIL async_reset_count: got %0d expected 0", Count); else passCount++;
    checkCount++; if (OutValid !== 4'b0) $display("FAIL async_reset_outvalid: got %b expected 0000", OutValid); else passCount++;
    checkCount++; if (ImemAddr !== 32'h0) $display("FAIL async_reset_addr: got %h expected 0", ImemAddr); else passCount++;
    mQ.delete();
    mPc = 32'h0;
    #1;
    Reset = 1'b0;
    ImemValid = 4'b1111;
    tick();
    checkCount++; if (OutPCp4[31:0] !== 32'd4) $display("FAIL post_reset_pcp4: got %h expected 4", OutPCp4[31:0]); else passCount++;
    checkCount++; if (ImemAddr !== 32'd16) $display("FAIL post_reset_addr: got %h expected 10", ImemAddr); else passCount++;
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 400; k++) begin
      ImemValid  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      r          = $urandom_range(0, 31);
      Branch     = (r == 0);
      Jump       = (r == 1) || (r == 2);
      BranchDest = $urandom;
      JumpDest   = $urandom;
      DeqCount   = 3'($urandom_range(0, (k < 200) ? 4 : 3));
      tick();
      checkCount++; if (Count !== 6'(mQ.size()))
        $display("FAIL rand_count[%0d]: got %0d expected %0d", k, Count, mQ.size()); else passCount++;
      checkCount++; if (ImemAddr !== mPc)
        $display("FAIL rand_addr[%0d]: got %h expected %h", k, ImemAddr, mPc); else passCount++;
      checkCount++; if (Full !== ((DEPTH - mQ.size()) < FW))
        $display("FAIL rand_full[%0d]: got %b expected %b", k, Full, (DEPTH - mQ.size()) < FW); else passCount++;
      checkCount++; if (Empty !== (mQ.size() == 0))
        $display("FAIL rand_empty[%0d]: got %b expected %b", k, Empty, mQ.size() == 0); else passCount++;
      for (int i = 0; i < FW; i++) begin
        checkCount++; if (OutValid[i] !== (i < mQ.size()))
          $display("FAIL rand_valid[%0d][%0d]: got %b expected %b", k, i, OutValid[i], i < mQ.size()); else passCount++;
        if (i < mQ.size()) begin
          checkCount++; if (OutPCp4[i*32 +: 32] !== mQ[i].pcp4)
            $display("FAIL rand_pcp4[%0d][%0d]: got %h expected %h", k, i, OutPCp4[i*32 +: 32], mQ[i].pcp4); else passCount++;
          checkCount++; if (OutInstr[i*32 +: 32] !== mQ[i].instr)
            $display("FAIL rand_instr[%0d][%0d]: got %h expected %h", k, i, OutInstr[i*32 +: 32], mQ[i].instr); else passCount++;
        end
      end
    end
    Branch = 1'b0;
    Jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_partial_mask();
    test_full_stall();
    test_push_pop();
    test_redirect();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
